// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame sender: FSM encoding, ASCII constants,
// frame geometry and the double-dabble add-3 helper.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SEND,
        DONE
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int FRAME_LEN  = 8;
    localparam int BIN_W      = 12;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    // Pre-shift correction: any nibble that would reach 10+ after doubling gets +3.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock, BIN_W steps.
// done is high during the cycle whose clock edge performs the final shift.
module bin2bcd_seq
    import uart_frame_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic             done
);

    localparam logic [3:0] LAST_STEP = 4'(BIN_W - 1);

    logic [BIN_W-1:0] shift_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [3:0]       step_q;
    logic             run_q;

    assign bcd_adj = bcd_add3(bcd_q);
    assign done    = run_q && (step_q == LAST_STEP);
    assign bcd_out = bcd_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            shift_q <= bin_in;
            bcd_q   <= '0;
            step_q  <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
            step_q           <= step_q + 4'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_frame_sender.sv
// Converts a 12-bit value to ASCII decimal and pushes "PREFIX SEP d3 d2 d1 d0 CR LF"
// into a TX FIFO. Define LEADING_ZERO_BLANK_EN to send leading zeros of d3..d1 as spaces.
module uart_frame_sender
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] PREFIX = 8'h44,
    parameter logic [7:0] SEP    = 8'h3D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_send,
    input  logic [11:0] i_send_data,
    input  logic        full,
    output logic        push,
    output logic [7:0]  send_data,
    output logic        tx_done,
    output logic        busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t           state_q;
    logic [2:0]       idx_q;
    logic             accept;
    logic             conv_done;
    logic [BCD_W-1:0] bcd;
    logic [2:0]       blank;
    logic [7:0]       frame_byte;

    assign accept = (state_q == IDLE) && start_send;

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .bin_in  (i_send_data),
        .bcd_out (bcd),
        .done    (conv_done)
    );

    // blank[k] marks frame byte 2+k as a leading zero to be sent as a space.
`ifdef LEADING_ZERO_BLANK_EN
    assign blank[0] = (bcd[15:12] == 4'd0);
    assign blank[1] = blank[0] && (bcd[11:8] == 4'd0);
    assign blank[2] = blank[1] && (bcd[7:4] == 4'd0);
`else
    assign blank = 3'b000;
`endif

    function automatic logic [7:0] digit_char(input logic [3:0] nib, input logic blanked);
        return blanked ? ASCII_SPACE : (ASCII_ZERO + {4'h0, nib});
    endfunction

    // NOTE: a default assignment ahead of the case keeps this block free of latches.
    always_comb begin
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = PREFIX;
            3'd1:    frame_byte = SEP;
            3'd2:    frame_byte = digit_char(bcd[15:12], blank[0]);
            3'd3:    frame_byte = digit_char(bcd[11:8],  blank[1]);
            3'd4:    frame_byte = digit_char(bcd[7:4],   blank[2]);
            3'd5:    frame_byte = digit_char(bcd[3:0],   1'b0);
            3'd6:    frame_byte = ASCII_CR;
            default: frame_byte = ASCII_LF;
        endcase
    end

    // Decoded from state so an asynchronous reset drops push in the same instant.
    assign push      = (state_q == SEND) && !full;
    assign send_data = (state_q == SEND) ? frame_byte : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_send) begin
                        state_q <= CONV;
                        busy    <= 1'b1;
                    end
                end
                CONV: begin
                    if (conv_done) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (push) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            tx_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    tx_done <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Scoreboard bench for uart_frame_sender: stimulus queues expected frame bytes from a
// decimal reference model; a negedge monitor pops and compares on every push.
module tb_uart_frame_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_send = 1'b0;
    logic [11:0] i_send_data = 12'd0;
    logic        full = 1'b0;
    logic        push;
    logic [7:0]  send_data;
    logic        tx_done;
    logic        busy;

    uart_frame_sender dut (
        .clk         (clk),
        .rst         (rst),
        .start_send  (start_send),
        .i_send_data (i_send_data),
        .full        (full),
        .push        (push),
        .send_data   (send_data),
        .tx_done     (tx_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         dc = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    bit         rand_full_en = 1'b0;
    logic [7:0] exp_q[$];
    int         push_cyc_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame built from decimal arithmetic on the value.
    function automatic void model_frame(input int v);
        int         d[4];
        bit         lead;
        logic [7:0] c;
        d[0] = v / 1000;
        d[1] = (v / 100) % 10;
        d[2] = (v / 10) % 10;
        d[3] = v % 10;
        lead = 1'b1;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h3D);
        for (int i = 0; i < 4; i++) begin
            c = 8'(8'h30 + d[i]);
`ifdef LEADING_ZERO_BLANK_EN
            if (i < 3 && lead && d[i] == 0) c = 8'h20;
`endif
            if (d[i] != 0) lead = 1'b0;
            exp_q.push_back(c);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (tx_done) done_cnt++;
                if (full) check("no_push_while_full", {31'd0, push}, 32'd0);
                if (push) begin
                    check("push_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) check("frame_byte", {24'd0, send_data}, {24'd0, exp_q.pop_front()});
                    push_cyc_q.push_back(cyc);
                end
            end
        end
    end

    // Random backpressure, only while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_full_en) full = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [11:0] v);
        @(negedge clk);
        i_send_data = v;
        start_send  = 1'b1;
        model_frame(int'(v));
        exp_done++;
        t0 = cyc;
        @(negedge clk);
        start_send  = 1'b0;
        i_send_data = 12'($urandom);
    endtask

    task automatic pulse_start(input logic [11:0] v);
        @(negedge clk);
        i_send_data = v;
        start_send  = 1'b1;
        @(negedge clk);
        start_send  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n  = 0;
        dc = -1;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (tx_done) begin
                dc = cyc;
                break;
            end
        end
        check("tx_done_seen", {31'd0, dc >= 0}, 32'd1);
    endtask

    task automatic wait_pushes(input int n);
        int k;
        k = 0;
        while (push_cyc_q.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("pushes_reached", {31'd0, push_cyc_q.size() >= n}, 32'd1);
    endtask

    initial begin
        // Reset state
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_push", {31'd0, push}, 32'd0);
        check("rst_send_data", {24'd0, send_data}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1234 with exact latency
        push_cyc_q.delete();
        start_frame(12'd1234);
        check("busy_in_conv", {31'd0, busy}, 32'd1);
        wait_done();
        check("done_cycle", 32'(dc - t0), 32'd21);
        check("push_count_1234", 32'(push_cyc_q.size()), 32'd8);
        if (push_cyc_q.size() == 8) begin
            check("first_push_cycle", 32'(push_cyc_q[0] - t0), 32'd13);
            check("last_push_cycle", 32'(push_cyc_q[7] - t0), 32'd20);
        end
        check("drained_1234", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("busy_low_after_done", {31'd0, busy}, 32'd0);

        // Extremes
        start_frame(12'd4095);
        wait_done();
        start_frame(12'd0);
        wait_done();
        check("drained_extremes", 32'(exp_q.size()), 32'd0);

        // Backpressure after the 3rd push
        push_cyc_q.delete();
        start_frame(12'd567);
        wait_pushes(3);
        full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_hold_data", {24'd0, send_data}, 32'h35);
        end
        @(posedge clk);
        #1 full = 1'b0;
        wait_done();
        check("push_count_567", 32'(push_cyc_q.size()), 32'd8);

        // Starts while busy are ignored
        push_cyc_q.delete();
        start_frame(12'd321);
        repeat (3) @(negedge clk);
        pulse_start(12'd999);
        wait_pushes(2);
        pulse_start(12'd998);
        wait_done();
        repeat (30) @(negedge clk);
        check("one_done_per_frame", 32'(done_cnt), 32'(exp_done));
        check("drained_ignore", 32'(exp_q.size()), 32'd0);

        // Back-to-back: start in first IDLE cycle after tx_done
        start_frame(12'd777);
        wait_done();
        start_frame(12'd42);
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_done();
        check("drained_b2b", 32'(exp_q.size()), 32'd0);

        // Reset mid-SEND
        push_cyc_q.delete();
        start_frame(12'd2024);
        wait_pushes(2);
        #2 rst = 1'b0;
        #1;
        check("abort_push", {31'd0, push}, 32'd0);
        check("abort_send_data", {24'd0, send_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        exp_done--;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume", {31'd0, push}, 32'd0);
        start_frame(12'd88);
        wait_done();
        check("drained_after_abort", 32'(exp_q.size()), 32'd0);

        // Random values under random backpressure
        rand_full_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            start_frame(12'($urandom_range(0, 4095)));
            wait_done();
        end
        rand_full_en = 1'b0;
        @(posedge clk);
        #1 full = 1'b0;

        repeat (5) @(negedge clk);
        check("total_done", 32'(done_cnt), 32'(exp_done));
        check("drained_final", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
